// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch/sequencing front end
package cpu_pkg;

  // One-hot stage phase driven to Control_unit
  localparam logic [4:0] TICK_NONE = 5'b00000;
  localparam logic [4:0] TICK_IF   = 5'b10000;
  localparam logic [4:0] TICK_ID   = 5'b01000;
  localparam logic [4:0] TICK_EX   = 5'b00100;
  localparam logic [4:0] TICK_MEM  = 5'b00010;
  localparam logic [4:0] TICK_WB   = 5'b00001;

  // Next-PC select codes returned by Control_unit
  localparam logic [2:0] PC_INC    = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b100;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_HOLD   = 3'b000;

  // Opcode field instruction[15:12], shared with Control_unit
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_ADDI   = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BEQ    = 4'hA;
  localparam logic [3:0] OP_JMP    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - combinational next-PC select and illegal-code detector
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instruction,
  input  logic [2:0]        pc_enables,
  output logic [ADDR_W-1:0] pc_next,
  output logic              is_halt,
  output logic              is_illegal
);

  logic [31:0] pc_ext;
  logic [31:0] br_off;
  logic        unused_opcode;

  assign pc_ext        = {{(32-ADDR_W){1'b0}}, pc};
  assign br_off        = {{24{instruction[7]}}, instruction[7:0]};
  // Opcode bits are decoded by Control_unit, not here
  assign unused_opcode = ^instruction[15:12];

  // Select the next PC; all arithmetic wraps silently at ADDR_W bits
  always_comb begin
    pc_next    = ADDR_W'(pc_ext + 32'd1);
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (pc_enables)
      PC_INC:    pc_next = ADDR_W'(pc_ext + 32'd1);
      PC_BRANCH: pc_next = ADDR_W'(pc_ext + 32'd1 + br_off);
      PC_JUMP:   pc_next = ADDR_W'(instruction[11:0]);
      PC_HOLD: begin
        pc_next = pc;
        is_halt = 1'b1;
      end
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch, IR/PC ownership and stage sequencing
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              imem_valid,
  input  logic [2:0]        pc_enables,
  output logic [15:0]       instruction,
  output logic [4:0]        tick,
  output logic              enable,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] pc_next;
  logic              is_halt;
  logic              is_illegal;

  pc_next_unit #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc),
    .instruction (instruction),
    .pc_enables  (pc_enables),
    .pc_next     (pc_next),
    .is_halt     (is_halt),
    .is_illegal  (is_illegal)
  );

  // State register; reset abandons any outstanding fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Instruction register loads only on the IF->ID edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             instruction <= 16'h0000;
    else if (state == ST_IF && imem_valid) instruction <= imem_data;
  end

  // PC and sticky error update on the edge leaving WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_PC;
      err <= 1'b0;
    end else if (state == ST_WB) begin
      pc  <= pc_next;
      err <= err | is_illegal;
    end
  end

  // Next-state logic; a started instruction always runs through WB
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (run) next_state = ST_IF;
      ST_IF:   if (imem_valid) next_state = ST_ID;
      ST_ID:   next_state = ST_EX;
      ST_EX:   next_state = ST_MEM;
      ST_MEM:  next_state = ST_WB;
      ST_WB: begin
        if (is_halt)  next_state = ST_HALT;
        else if (run) next_state = ST_IF;
        else          next_state = ST_IDLE;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    tick     = TICK_NONE;
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_IF: begin
        tick     = TICK_IF;
        imem_req = 1'b1;
      end
      ST_ID:   tick = TICK_ID;
      ST_EX:   tick = TICK_EX;
      ST_MEM:  tick = TICK_MEM;
      ST_WB:   tick = TICK_WB;
      ST_HALT: halted = 1'b1;
      default: tick = TICK_NONE;
    endcase
    enable    = |tick;
    imem_addr = pc;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [2:0]  pc_enables;
  logic [15:0] instruction;
  logic [4:0]  tick;
  logic        enable;
  logic [7:0]  pc;
  logic        halted;
  logic        err;

  logic [15:0] mem [0:255];
  logic [15:0] exp_instr_q [$];
  logic [7:0]  exp_pc_q [$];
  logic [7:0]  model_pc;
  logic [15:0] model_instr;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .pc_enables  (pc_enables),
    .instruction (instruction),
    .tick        (tick),
    .enable      (enable),
    .pc          (pc),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":tick"},  {27'd0, tick}, 32'h0);
    chk({tag, ":en"},    {31'd0, enable}, 32'h0);
    chk({tag, ":req"},   {31'd0, imem_req}, 32'h0);
    chk({tag, ":pc"},    {24'd0, pc}, 32'h0);
    chk({tag, ":instr"}, {16'd0, instruction}, 32'h0);
    chk({tag, ":halt"},  {31'd0, halted}, 32'h0);
    chk({tag, ":err"},   {31'd0, err}, 32'h0);
  endtask

  // One full instruction: IF (with wait_n stall cycles) through WB, then the PC check
  task automatic run_instr(input string nm, input logic [15:0] word, input logic [2:0] pcen,
                           input int wait_n, input bit from_idle, input bit run_after,
                           input logic [7:0] exp_pc, input logic exp_err);
    logic [15:0] want_i;
    logic [7:0]  want_pc;
    mem[model_pc] = word;
    exp_instr_q.push_back(word);
    exp_pc_q.push_back(exp_pc);
    run        = 1'b1;
    pc_enables = pcen;
    if (from_idle) begin
      imem_valid = 1'b0;
      chk({nm, ":idle_tick"}, {27'd0, tick}, 32'h0);
      @(negedge clk);
    end
    for (int k = 0; k <= wait_n; k++) begin
      chk({nm, ":if_tick"},  {27'd0, tick}, 32'h10);
      chk({nm, ":if_req"},   {31'd0, imem_req}, 32'h1);
      chk({nm, ":if_addr"},  {24'd0, imem_addr}, {24'd0, model_pc});
      chk({nm, ":if_instr"}, {16'd0, instruction}, {16'd0, model_instr});
      imem_valid = (k == wait_n);
      @(negedge clk);
    end
    imem_valid = 1'b0;
    want_i = exp_instr_q.pop_front();
    chk({nm, ":id_tick"},  {27'd0, tick}, 32'h08);
    chk({nm, ":id_req"},   {31'd0, imem_req}, 32'h0);
    chk({nm, ":id_instr"}, {16'd0, instruction}, {16'd0, want_i});
    @(negedge clk);
    chk({nm, ":ex_tick"},  {27'd0, tick}, 32'h04);
    @(negedge clk);
    chk({nm, ":mem_tick"}, {27'd0, tick}, 32'h02);
    @(negedge clk);
    chk({nm, ":wb_tick"},  {27'd0, tick}, 32'h01);
    chk({nm, ":wb_en"},    {31'd0, enable}, 32'h1);
    chk({nm, ":wb_instr"}, {16'd0, instruction}, {16'd0, want_i});
    run = run_after;
    @(negedge clk);
    want_pc = exp_pc_q.pop_front();
    chk({nm, ":pc"},  {24'd0, pc}, {24'd0, want_pc});
    chk({nm, ":err"}, {31'd0, err}, {31'd0, exp_err});
    model_pc    = want_pc;
    model_instr = word;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset       = 1'b1;
    run         = 1'b0;
    imem_valid  = 1'b0;
    pc_enables  = 3'b010;
    model_pc    = 8'h00;
    model_instr = 16'h0000;

    @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_run", {27'd0, tick}, 32'h0);

    run_instr("basic",   16'h1105, 3'b010, 0, 1'b1, 1'b1, 8'h01, 1'b0);
    run_instr("wait3",   16'h2222, 3'b010, 3, 1'b0, 1'b1, 8'h02, 1'b0);
    run_instr("jmp10",   16'hF010, 3'b001, 0, 1'b0, 1'b1, 8'h10, 1'b0);
    run_instr("br_back", 16'hA0FE, 3'b100, 1, 1'b0, 1'b1, 8'h0F, 1'b0);
    run_instr("jmpff",   16'h00FF, 3'b001, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_instr("br_wrap", 16'h0001, 3'b100, 0, 1'b0, 1'b1, 8'h01, 1'b0);
    run_instr("jmp23",   16'hF123, 3'b001, 2, 1'b0, 1'b1, 8'h23, 1'b0);
    run_instr("jmp05",   16'h0005, 3'b001, 0, 1'b0, 1'b1, 8'h05, 1'b0);
    run_instr("illegal", 16'h3333, 3'b110, 0, 1'b0, 1'b1, 8'h06, 1'b1);
    run_instr("sticky",  16'h4444, 3'b010, 1, 1'b0, 1'b0, 8'h07, 1'b1);
    chk("stop_idle_tick", {27'd0, tick}, 32'h0);
    chk("stop_idle_halt", {31'd0, halted}, 32'h0);
    run_instr("halt",    16'h5555, 3'b000, 0, 1'b1, 1'b1, 8'h07, 1'b1);
    chk("halt_flag", {31'd0, halted}, 32'h1);
    chk("halt_tick", {27'd0, tick}, 32'h0);
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    imem_valid = 1'b0;
    chk("halt_stays", {31'd0, halted}, 32'h1);
    chk("halt_pc",    {24'd0, pc}, 32'h07);
    chk("halt_req",   {31'd0, imem_req}, 32'h0);

    // Asynchronous reset while in EX
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_halt");
    @(negedge clk);
    reset = 1'b0;
    mem[0] = 16'h1105;
    run = 1'b1;
    imem_valid = 1'b1;
    @(negedge clk);
    chk("pre_ex_if", {27'd0, tick}, 32'h10);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    chk("pre_ex_tick",  {27'd0, tick}, 32'h04);
    chk("pre_ex_instr", {16'd0, instruction}, 32'h1105);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_ex");
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset during an IF wait, then a late response
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wait_if_tick", {27'd0, tick}, 32'h10);
    chk("wait_if_req",  {31'd0, imem_req}, 32'h1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_if");
    run = 1'b0;
    imem_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_valid = 1'b0;
    chk("late_valid_instr", {16'd0, instruction}, 32'h0);
    chk("late_valid_tick",  {27'd0, tick}, 32'h0);
    chk("late_valid_req",   {31'd0, imem_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and stage-sequencing block sitting directly upstream of `Control_unit`. It owns the program counter and the instruction register, and fetches 16-bit instructions from an instruction memory over a valid handshake. It drives the one-hot `tick` phase and the `enable` consumed by `Control_unit`. At the end of write-back it updates the PC from the `PC_enables` that `Control_unit` returns.

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `run`, in, 1: level; high permits starting or continuing execution.
- `imem_req`, out, 1: fetch request, held until `imem_valid`.
- `imem_addr`, out, `ADDR_W`: fetch address, equal to `pc`.
- `imem_data`, in, 16: instruction word, sampled when `imem_req && imem_valid`.
- `imem_valid`, in, 1: memory response strobe; ignored while `imem_req` is low.
- `pc_enables`, in, 3: next-PC select from `Control_unit` (`PC_enables`).
- `instruction`, out, 16: instruction register, to `Control_unit`.
- `tick`, out, 5: one-hot phase: IF=10000, ID=01000, EX=00100, MEM=00010, WB=00001, idle=00000.
- `enable`, out, 1: to `Control_unit`; high whenever `tick` is non-zero.
- `pc`, out, `ADDR_W`: current program counter.
- `halted`, out, 1: high in HALT state.
- `err`, out, 1: sticky illegal-`pc_enables` flag.

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT. `tick` is decoded from the state; it is 00000 in IDLE and HALT.
- IDLE: if `run`=1, go to IF next cycle.
- IF: `imem_req`=1, `imem_addr`=`pc`.
  - On a cycle with `imem_valid`=1: load `instruction`<=`imem_data`, drop `imem_req`, go to ID.
  - Otherwise remain in IF. `instruction` keeps its previous value.
- ID -> EX -> MEM -> WB: one cycle each, unconditional.
- WB: sample `pc_enables` on the exiting edge and load the PC as follows. All arithmetic is modulo 2^ADDR_W, and wrap is silent.
  - 010: `pc`<=`pc`+1.
  - 100 (taken branch): `pc`<=`pc`+1+sext(`instruction[7:0]`), truncated to ADDR_W.
  - 001 (jump): `pc`<=`instruction[11:0]`, zero-extended or truncated to ADDR_W.
  - 000: `pc` unchanged; go to HALT.
  - Any other code: treat as 010 and set `err`=1.
- WB exit: go to IF if `run`=1, else to IDLE. Deasserting `run` mid-instruction never aborts the instruction; it completes through WB.
- HALT: exited only by `reset`.
- Reset values: state IDLE, `pc`=`RESET_PC`, `instruction`=16'h0000, `tick`=00000, `enable`=0, `imem_req`=0, `halted`=0, `err`=0.
- Reset asserted mid-operation immediately forces all reset values, including abandoning an outstanding request. A `imem_valid` arriving after reset is ignored.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Fetch latency: `imem_req` rises on the IF entry cycle. If `imem_valid` is high in that same cycle, IF lasts exactly one cycle.
- Minimum 5 cycles per instruction; each fetch wait cycle adds one.
- `instruction` changes only on the IF->ID edge, so it is stable throughout ID..WB.
- `pc_enables` must be stable during the WB cycle. `Control_unit` sets it within WB, and it is sampled at the WB-exiting edge.
- New `pc` is visible in the cycle the next IF begins, so `imem_addr` is correct on the first request cycle.
- IDLE->IF takes one cycle after `run` is seen high.

## Structure
- Shared package `cpu_pkg` holds:
  - tick one-hot constants `TICK_IF`..`TICK_WB` and `TICK_NONE`;
  - PC-select codes `PC_INC`=010, `PC_BRANCH`=100, `PC_JUMP`=001, `PC_HOLD`=000;
  - opcode constants shared with `Control_unit`.
- One sub-module: `pc_next_unit`, a combinational next-PC and illegal-code detector taking `pc`, `instruction`, `pc_enables` and producing `pc_next`, `is_halt`, `is_illegal`.
- The FSM and registers stay in the top level.

## Test plan
- Reset, `run`=1, `imem_valid` tied high, memory returns 16'h1105 at addr 0 -> `tick` steps 10000,01000,00100,00010,00001 in 5 cycles, `instruction`=16'h1105, `pc`=1 after WB with `pc_enables`=010.
- `imem_valid` delayed 3 cycles -> IF tick held for 4 cycles, `imem_req` high throughout, then drops the cycle after capture; `instruction` unchanged until capture.
- `pc`=8'h10, `instruction`=16'hA0FE, `pc_enables`=100 -> `pc`=8'h0F. With `pc`=8'hFF, imm 8'h01 -> `pc`=8'h01 (wrap).
- `instruction`=16'hF123, `pc_enables`=001, `ADDR_W`=8 -> `pc`=8'h23. Then `pc_enables`=000 -> `halted`=1, `tick`=00000, `pc` unchanged.
- `pc_enables`=110 in WB at `pc`=5 -> `pc`=6, `err`=1 and stays set across later instructions.
- `reset` pulsed during EX with `imem_req` low, and again during an IF wait -> all outputs at reset values asynchronously. A late `imem_valid` does not load `instruction`.
